// File: rtl/move_collector_if.sv
// Bus between the move collector, the square-unit FIFO array and the move-list consumer.
// The master modport is the collector; the slave modport is the surrounding board logic.
interface move_collector_if #(
    parameter int NSQ   = 64,
    parameter int SLOTS = 8
);
    logic                  start;
    logic                  all_done;
    logic [NSQ-1:0]        fifo_empty;
    logic [19*SLOTS-1:0]   fifo_q;
    logic [5:0]            sel;
    logic [NSQ-1:0]        rd_en;
    logic [18:0]           move_data;
    logic                  move_valid;
    logic                  move_ready;
    logic [7:0]            move_count;
    logic                  busy;
    logic                  finished;

    modport master (
        input  start, all_done, fifo_empty, fifo_q, move_ready,
        output sel, rd_en, move_data, move_valid, move_count, busy, finished
    );

    modport slave (
        output start, all_done, fifo_empty, fifo_q, move_ready,
        input  sel, rd_en, move_data, move_valid, move_count, busy, finished
    );
endinterface

// File: rtl/move_collector.sv
// Drains the per-square move FIFOs in square order, unpacks each word into 19-bit
// move slots and streams the valid ones over a valid/ready handshake.
module move_collector #(
    parameter int NSQ   = 64,
    parameter int SLOTS = 8
) (
    input  logic             clk,
    input  logic             reset,
    move_collector_if.master mc
);
    localparam int         W         = 19 * SLOTS;
    localparam logic [5:0] LAST_SQ   = 6'(NSQ - 1);
    localparam logic [2:0] LAST_SLOT = 3'(SLOTS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAITD, S_SCAN, S_READ, S_LATCH, S_EMIT, S_FIN
    } state_t;

    state_t         r_state,    w_state_nxt;
    logic [5:0]     r_sel,      w_sel_nxt;
    logic [W-1:0]   r_word,     w_word_nxt;
    logic [2:0]     r_slot,     w_slot_nxt;
    logic [18:0]    r_data,     w_data_nxt;
    logic           r_valid,    w_valid_nxt;
    logic [7:0]     r_count,    w_count_nxt;
    logic [NSQ-1:0] r_rd_en,    w_rd_en_nxt;
    logic           r_busy,     w_busy_nxt;
    logic           r_finished, w_finished_nxt;

    logic [2:0]     w_slot_dec;
    logic [18:0]    w_next_move;
    logic [18:0]    w_first_move;

    assign w_slot_dec   = r_slot - 3'd1;
    assign w_next_move  = r_word[19*int'(w_slot_dec) +: 19];
    assign w_first_move = mc.fifo_q[W-1 -: 19];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_word     <= '0;
            r_slot     <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_count    <= '0;
            r_rd_en    <= '0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_word     <= w_word_nxt;
            r_slot     <= w_slot_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_count    <= w_count_nxt;
            r_rd_en    <= w_rd_en_nxt;
            r_busy     <= w_busy_nxt;
            r_finished <= w_finished_nxt;
        end
    end

    // Outputs are registered, so each one is computed here from the state being entered.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_word_nxt  = r_word;
        w_slot_nxt  = r_slot;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_count_nxt = r_count;
        w_rd_en_nxt = '0;

        case (r_state)
            S_IDLE: begin
                if (mc.start) begin
                    w_count_nxt = '0;
                    w_sel_nxt   = '0;
                    w_state_nxt = S_WAITD;
                end
            end
            S_WAITD: begin
                if (mc.all_done) w_state_nxt = S_SCAN;
            end
            S_SCAN: begin
                if (!mc.fifo_empty[r_sel]) begin
                    w_state_nxt        = S_READ;
                    w_rd_en_nxt[r_sel] = 1'b1;
                end else if (r_sel == LAST_SQ) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_sel_nxt = r_sel + 6'd1;
                end
            end
            S_READ: begin
                w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_word_nxt  = mc.fifo_q;
                w_slot_nxt  = LAST_SLOT;
                w_valid_nxt = ~w_first_move[18];
                if (!w_first_move[18]) w_data_nxt = w_first_move;
                w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                // An invalid slot sits for one cycle with move_valid low; a valid one waits for ready.
                if (!r_valid || mc.move_ready) begin
                    if (r_valid && r_count != 8'hFF) w_count_nxt = r_count + 8'd1;
                    if (r_slot == 3'd0) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_SCAN;
                    end else begin
                        w_slot_nxt  = w_slot_dec;
                        w_valid_nxt = ~w_next_move[18];
                        if (!w_next_move[18]) w_data_nxt = w_next_move;
                    end
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt     = (w_state_nxt != S_IDLE);
        w_finished_nxt = (w_state_nxt == S_FIN);
    end

    assign mc.sel        = r_sel;
    assign mc.rd_en      = r_rd_en;
    assign mc.move_data  = r_data;
    assign mc.move_valid = r_valid;
    assign mc.move_count = r_count;
    assign mc.busy       = r_busy;
    assign mc.finished   = r_finished;
endmodule

// File: tb/tb_move_collector.sv
// Scoreboarded bench for move_collector: a FIFO model feeds words, expected moves are
// queued by the stimulus and popped by a monitor on every handshake.
module tb_move_collector;
    localparam int NSQ   = 64;
    localparam int SLOTS = 8;
    localparam int W     = 19 * SLOTS;
    localparam logic [18:0] INV = 19'h40000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    move_collector_if #(.NSQ(NSQ), .SLOTS(SLOTS)) bus();
    move_collector #(.NSQ(NSQ), .SLOTS(SLOTS)) dut (.clk(clk), .reset(reset), .mc(bus));

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    logic [W-1:0] mem [NSQ][4];
    int           wcnt [NSQ] = '{default: 0};
    int           rp   [NSQ] = '{default: 0};
    int           rd_cnt [NSQ] = '{default: 0};
    logic         model_clr = 1'b0;
    logic [W-1:0] q_r = '0;
    logic [18:0]  expq [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO array model: q is valid the cycle after the read request.
    always @(posedge clk) begin
        if (model_clr) begin
            for (int n = 0; n < NSQ; n++) rp[n] <= 0;
        end else begin
            for (int n = 0; n < NSQ; n++)
                if (bus.rd_en[n]) begin
                    if (rp[n] < wcnt[n]) q_r <= mem[n][rp[n]];
                    rp[n] <= rp[n] + 1;
                end
        end
    end
    assign bus.fifo_q = q_r;

    always_comb begin
        bus.fifo_empty = '1;
        for (int n = 0; n < NSQ; n++) bus.fifo_empty[n] = (rp[n] >= wcnt[n]);
    end

    // Monitor: handshake scoreboard, stall stability, rd_en shape.
    logic        p_valid = 1'b0, p_ready = 1'b0, p_reset = 1'b1;
    logic [18:0] p_data  = '0;
    logic [18:0] mon_e;
    always @(negedge clk) begin
        if (!p_reset && !reset && p_valid && !p_ready) begin
            check("stall_valid", 64'(bus.move_valid), 64'd1);
            check("stall_data", 64'(bus.move_data), 64'(p_data));
        end
        if (bus.move_valid && bus.move_ready && !reset) begin
            if (expq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_move: got %0h, expected none", bus.move_data);
            end else begin
                mon_e = expq.pop_front();
                check("move", 64'(bus.move_data), 64'(mon_e));
            end
        end
        if (bus.rd_en != '0) begin
            check("rd_onehot", 64'($countones(bus.rd_en)), 64'd1);
            for (int n = 0; n < NSQ; n++)
                if (bus.rd_en[n]) rd_cnt[n] <= rd_cnt[n] + 1;
        end
        p_valid <= bus.move_valid;
        p_ready <= bus.move_ready;
        p_data  <= bus.move_data;
        p_reset <= reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rd_total();
        int s = 0;
        for (int n = 0; n < NSQ; n++) s += rd_cnt[n];
        return s;
    endfunction

    function automatic logic [18:0] full_slot(input int base, input int k);
        return {1'b0, 6'(base + k), 6'(k), 6'(63 - k)};
    endfunction

    function automatic logic [W-1:0] full_word(input int base);
        logic [W-1:0] w;
        for (int k = 0; k < SLOTS; k++) w[19*k +: 19] = full_slot(base, k);
        return w;
    endfunction

    task automatic push_full(input int base);
        for (int k = SLOTS - 1; k >= 0; k--) expq.push_back(full_slot(base, k));
    endtask

    task automatic clear_model();
        for (int n = 0; n < NSQ; n++) wcnt[n] = 0;
        model_clr = 1'b1;
        tick();
        model_clr = 1'b0;
    endtask

    task automatic pulse_start(output int at);
        at = cyc;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_fin(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (bus.finished) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL finish_timeout: got no finished pulse, expected one within %0d cycles", budget);
        end
    endtask

    task automatic wait_valid(input int budget);
        int ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (bus.move_valid) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (ok == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL valid_timeout: got no move_valid, expected one within %0d cycles", budget);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},      64'(bus.sel),        64'd0);
        check({tag, "_rd_en"},    64'(bus.rd_en),      64'd0);
        check({tag, "_valid"},    64'(bus.move_valid), 64'd0);
        check({tag, "_data"},     64'(bus.move_data),  64'd0);
        check({tag, "_count"},    64'(bus.move_count), 64'd0);
        check({tag, "_busy"},     64'(bus.busy),       64'd0);
        check({tag, "_finished"}, 64'(bus.finished),   64'd0);
    endtask

    logic [18:0]  m_a, m_b;
    logic [W-1:0] w_part;
    int s_at, f_at, j_at, rd_base;

    initial begin
        m_a = {7'b0010000, 6'o14, 6'o24};
        m_b = {7'b0000001, 6'o14, 6'o25};
        for (int k = 0; k < SLOTS; k++) w_part[19*k +: 19] = INV;
        w_part[19*7 +: 19] = m_a;
        w_part[19*3 +: 19] = m_b;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.all_done = 1'b0;
        bus.move_ready = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Empty board
        clear_model();
        bus.all_done = 1'b1;
        rd_base = rd_total();
        pulse_start(s_at);
        wait_fin(200, f_at);
        check("empty_latency", 64'(f_at - s_at), 64'd66);
        check("empty_count", 64'(bus.move_count), 64'd0);
        check("empty_rd", 64'(rd_total() - rd_base), 64'd0);
        tick();
        check("empty_idle_busy", 64'(bus.busy), 64'd0);

        // Single word with partial slots, consumer always ready
        clear_model();
        mem[12][0] = w_part;
        wcnt[12] = 1;
        expq.push_back(m_a);
        expq.push_back(m_b);
        bus.move_ready = 1'b1;
        rd_base = rd_cnt[12];
        pulse_start(s_at);
        wait_fin(300, f_at);
        check("single_count", 64'(bus.move_count), 64'd2);
        check("single_rd12", 64'(rd_cnt[12] - rd_base), 64'd1);
        check("single_drained", 64'(expq.size()), 64'd0);
        tick();

        // Backpressure on the first move
        clear_model();
        mem[12][0] = w_part;
        wcnt[12] = 1;
        expq.push_back(m_a);
        expq.push_back(m_b);
        bus.move_ready = 1'b0;
        pulse_start(s_at);
        wait_valid(200);
        repeat (5) tick();
        check("bp_valid", 64'(bus.move_valid), 64'd1);
        check("bp_data", 64'(bus.move_data), 64'(m_a));
        check("bp_count_stalled", 64'(bus.move_count), 64'd0);
        bus.move_ready = 1'b1;
        wait_fin(300, f_at);
        check("bp_count", 64'(bus.move_count), 64'd2);
        check("bp_drained", 64'(expq.size()), 64'd0);
        tick();

        // Two full words in the last square
        clear_model();
        mem[63][0] = full_word(1);
        mem[63][1] = full_word(9);
        wcnt[63] = 2;
        push_full(1);
        push_full(9);
        rd_base = rd_cnt[63];
        pulse_start(s_at);
        wait_fin(400, f_at);
        check("multi_count", 64'(bus.move_count), 64'd16);
        check("multi_rd63", 64'(rd_cnt[63] - rd_base), 64'd2);
        check("multi_drained", 64'(expq.size()), 64'd0);
        tick();

        // Reset while a move is being offered
        clear_model();
        mem[5][0] = full_word(20);
        wcnt[5] = 1;
        bus.move_ready = 1'b0;
        pulse_start(s_at);
        wait_valid(200);
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        reset = 1'b0;
        expq.delete();
        clear_model();
        mem[5][0] = full_word(20);
        wcnt[5] = 1;
        push_full(20);
        bus.move_ready = 1'b1;
        pulse_start(s_at);
        check("restart_sel", 64'(bus.sel), 64'd0);
        check("restart_busy", 64'(bus.busy), 64'd1);
        wait_fin(300, f_at);
        check("restart_count", 64'(bus.move_count), 64'd8);
        check("restart_drained", 64'(expq.size()), 64'd0);
        tick();

        // Start before the square units are done; a second start is ignored
        clear_model();
        bus.all_done = 1'b0;
        pulse_start(s_at);
        repeat (3) tick();
        check("gate_busy", 64'(bus.busy), 64'd1);
        check("gate_sel", 64'(bus.sel), 64'd0);
        check("gate_fin", 64'(bus.finished), 64'd0);
        pulse_start(s_at);
        check("gate_busy2", 64'(bus.busy), 64'd1);
        j_at = cyc;
        bus.all_done = 1'b1;
        wait_fin(200, f_at);
        check("gate_latency", 64'(f_at - j_at), 64'd65);
        check("gate_count", 64'(bus.move_count), 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
